// File: rtl/microtile_edge_counter_pkg.sv
// ---------------------------------------------------------------------------
// microtile_pkg: channel limits and ui_in bit positions for the edge counter.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package microtile_pkg;

  localparam int MAX_CH   = 4;
  localparam int EV_LSB   = 0;
  localparam int MODE_BIT = 4;
  localparam int CLR_BIT  = 5;
  localparam int SEL_LSB  = 6;
  localparam int SEL_W    = 2;

endpackage

`default_nettype wire

// File: rtl/microtile_edge_counter_if.sv
// ---------------------------------------------------------------------------
// microtile_edge_counter_if: tile-side enable, input byte and output byte.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface microtile_edge_counter_if;

  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  modport master (output ena, output ui_in, input uo_out);
  modport slave  (input ena, input ui_in, output uo_out);

endinterface

`default_nettype wire

// File: rtl/microtile_edge_counter_sync_chain.sv
// ---------------------------------------------------------------------------
// sync_chain: 1-bit synchroniser with asynchronous active-low reset.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage <= {stage[STAGES-2:0], d};
    end
  end

  assign q = stage[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/microtile_edge_counter.sv
// ---------------------------------------------------------------------------
// microtile_edge_counter: per-channel edge counters with clear, enable,
// rising/both-edge mode and a combinational channel-select output mux.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module microtile_edge_counter
  import microtile_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit SATURATE    = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  microtile_edge_counter_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
    $error("NUM_CH must be in 1..%0d", MAX_CH);
  end
  if (CNT_W < 2 || CNT_W > 8) begin : g_bad_cnt_w
    $error("CNT_W must be in 2..8");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("SYNC_STAGES must be in 2..3");
  end

  logic [CLR_BIT:0] synced;

  for (genvar b = 0; b <= CLR_BIT; b++) begin : g_sync
    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (bus.ui_in[b]),
      .q     (synced[b])
    );
  end

  // Event bits above NUM_CH are synchronised but deliberately ignored.
  logic unused_synced;
  assign unused_synced = ^synced;

  logic              mode;
  logic              clear;
  logic [NUM_CH-1:0] ev_now;
  logic [NUM_CH-1:0] ev_prev;
  logic [NUM_CH-1:0] ev_hit;

  assign mode   = synced[MODE_BIT];
  assign clear  = synced[CLR_BIT];
  assign ev_now = synced[EV_LSB +: NUM_CH];

  // History keeps tracking while ena is low, so missed edges are never replayed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_prev <= '0;
    end else begin
      ev_prev <= ev_now;
    end
  end

  assign ev_hit = (ev_now & ~ev_prev) | ({NUM_CH{mode}} & ~ev_now & ev_prev);

  logic [CNT_W-1:0] cnt [NUM_CH];

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt[ch] <= '0;
      end else if (clear) begin
        cnt[ch] <= '0;
      end else if (bus.ena && ev_hit[ch]) begin
        if (cnt[ch] == CNT_MAX) begin
          cnt[ch] <= SATURATE ? CNT_MAX : '0;
        end else begin
          cnt[ch] <= cnt[ch] + CNT_ONE;
        end
      end
    end
  end

  logic [SEL_W-1:0] sel;
  logic [7:0]       mux_out;

  assign sel = bus.ui_in[SEL_LSB +: SEL_W];

  always_comb begin
    mux_out = 8'h00;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (sel == SEL_W'(ch)) begin
        mux_out = 8'(cnt[ch]);
      end
    end
  end

  assign bus.uo_out = mux_out;

endmodule

`default_nettype wire

// File: tb/tb_microtile_edge_counter.sv
// ---------------------------------------------------------------------------
// tb_microtile_edge_counter: four differently configured counters driven in parallel.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_microtile_edge_counter;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena   = 1'b1;
  logic [7:0] ui_in = 8'hFF;

  always #5 clk = ~clk;

  microtile_edge_counter_if bus0 ();
  microtile_edge_counter_if bus1 ();
  microtile_edge_counter_if bus2 ();
  microtile_edge_counter_if bus3 ();

  assign bus0.ena = ena;  assign bus0.ui_in = ui_in;
  assign bus1.ena = ena;  assign bus1.ui_in = ui_in;
  assign bus2.ena = ena;  assign bus2.ui_in = ui_in;
  assign bus3.ena = ena;  assign bus3.ui_in = ui_in;

  microtile_edge_counter #(.NUM_CH(4), .CNT_W(8), .SYNC_STAGES(2), .SATURATE(1'b0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  microtile_edge_counter #(.NUM_CH(4), .CNT_W(4), .SYNC_STAGES(3), .SATURATE(1'b1))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  microtile_edge_counter #(.NUM_CH(4), .CNT_W(4), .SYNC_STAGES(2), .SATURATE(1'b0))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  microtile_edge_counter #(.NUM_CH(2), .CNT_W(8), .SYNC_STAGES(2), .SATURATE(1'b0))
    dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  logic [7:0] outs [4];
  assign outs[0] = bus0.uo_out;
  assign outs[1] = bus1.uo_out;
  assign outs[2] = bus2.uo_out;
  assign outs[3] = bus3.uo_out;

  int nch [4] = '{4, 4, 4, 2};
  int wid [4] = '{8, 4, 4, 8};
  bit sat [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic            en;
    logic [7:0]      ui;
    logic [3:0]      mask;
    int              n;
    logic [3:0][7:0] exp;
  } step_t;

  step_t tbl [17];

  function automatic step_t mk(input logic en, input logic [7:0] ui, input logic [3:0] mask,
                               input int n, input logic [7:0] e0, input logic [7:0] e1,
                               input logic [7:0] e2, input logic [7:0] e3);
    step_t s;
    s.en = en; s.ui = ui; s.mask = mask; s.n = n;
    s.exp = {e3, e2, e1, e0};
    return s;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 8'h%02h, expected 8'h%02h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulses(input logic [3:0] mask, input int n);
    for (int i = 0; i < n; i++) begin
      ui_in[3:0] = ui_in[3:0] | mask;
      tick(3);
      ui_in[3:0] = ui_in[3:0] & ~mask;
      tick(3);
    end
  endtask

  // Reference: each counter is an integer modulo 2^W (or clamped at 2^W-1).
  int m [4][4];

  function automatic int bump(input int v, input int w, input bit s);
    int top;
    top = (1 << w) - 1;
    if (s) return (v + 1 > top) ? top : v + 1;
    return (v + 1) % (1 << w);
  endfunction

  initial begin
    logic [3:0] old_ev, new_ev, rise, fall;
    logic       r_en, r_clr, r_mode;
    logic [1:0] r_sel;

    tbl[0]  = mk(1'b1, 8'h20, 4'h0,  0, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[1]  = mk(1'b1, 8'h00, 4'h1,  5, 8'h05, 8'h05, 8'h05, 8'h05);
    tbl[2]  = mk(1'b1, 8'h50, 4'h6,  3, 8'h06, 8'h06, 8'h06, 8'h06);
    tbl[3]  = mk(1'b1, 8'h90, 4'h0,  0, 8'h06, 8'h06, 8'h06, 8'h00);
    tbl[4]  = mk(1'b1, 8'hC0, 4'h8, 17, 8'h11, 8'h0F, 8'h01, 8'h00);
    tbl[5]  = mk(1'b1, 8'h00, 4'h0,  0, 8'h05, 8'h05, 8'h05, 8'h05);
    tbl[6]  = mk(1'b1, 8'h40, 4'hC,  2, 8'h06, 8'h06, 8'h06, 8'h06);
    tbl[7]  = mk(1'b1, 8'h20, 4'h0,  0, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[8]  = mk(1'b1, 8'h00, 4'h1,  9, 8'h09, 8'h09, 8'h09, 8'h09);
    tbl[9]  = mk(1'b1, 8'h21, 4'h0,  0, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[10] = mk(1'b1, 8'h01, 4'h0,  0, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[11] = mk(1'b1, 8'h00, 4'h0,  0, 8'h00, 8'h00, 8'h00, 8'h00);
    tbl[12] = mk(1'b1, 8'h00, 4'h1,  3, 8'h03, 8'h03, 8'h03, 8'h03);
    tbl[13] = mk(1'b0, 8'h00, 4'h1,  4, 8'h03, 8'h03, 8'h03, 8'h03);
    tbl[14] = mk(1'b1, 8'h00, 4'h1,  2, 8'h05, 8'h05, 8'h05, 8'h05);
    tbl[15] = mk(1'b0, 8'h10, 4'h1,  2, 8'h05, 8'h05, 8'h05, 8'h05);
    tbl[16] = mk(1'b1, 8'h10, 4'h1,  1, 8'h07, 8'h07, 8'h07, 8'h07);

    // Reset with all inputs high, then release with ch0 held high.
    tick(3);
    for (int d = 0; d < 4; d++) check($sformatf("rst_ff_d%0d", d), outs[d], 8'h00);
    ui_in = 8'h3F;
    #1;
    check("rst_sel0_d0", outs[0], 8'h00);
    ui_in = 8'h01;
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    check("rel_2clk_d0", outs[0], 8'h00);
    tick(1);
    check("rel_3clk_d0", outs[0], 8'h01);
    check("rel_3clk_d2", outs[2], 8'h01);
    check("rel_3clk_d3", outs[3], 8'h01);
    check("rel_3clk_d1", outs[1], 8'h00);
    tick(1);
    check("rel_4clk_d1", outs[1], 8'h01);
    ui_in[7:6] = 2'd1;
    #1;
    check("sel1_comb_d0", outs[0], 8'h00);
    ui_in[7:6] = 2'd0;
    #1;
    check("sel0_comb_d0", outs[0], 8'h01);

    for (int i = 0; i < 17; i++) begin
      ena   = tbl[i].en;
      ui_in = tbl[i].ui;
      tick(6);
      pulses(tbl[i].mask, tbl[i].n);
      tick(6);
      for (int d = 0; d < 4; d++)
        check($sformatf("step%0d_d%0d", i, d), outs[d], tbl[i].exp[d]);
    end

    // Randomised phase against the integer model.
    ena   = 1'b1;
    ui_in = 8'h20;
    tick(6);
    ui_in = 8'h00;
    tick(6);
    for (int d = 0; d < 4; d++)
      for (int c = 0; c < 4; c++) m[d][c] = 0;

    for (int it = 0; it < 40; it++) begin
      old_ev = ui_in[3:0];
      new_ev = 4'($urandom);
      r_en   = ($urandom % 4) != 0;
      r_clr  = ($urandom % 8) == 0;
      r_mode = 1'($urandom);
      r_sel  = 2'($urandom);
      ena    = r_en;
      ui_in  = {r_sel, r_clr, r_mode, old_ev};
      tick(6);
      ui_in[3:0] = new_ev;
      tick(6);
      rise = new_ev & ~old_ev;
      fall = ~new_ev & old_ev;
      for (int d = 0; d < 4; d++)
        for (int c = 0; c < nch[d]; c++) begin
          if (r_clr) m[d][c] = 0;
          else if (r_en && (rise[c] || (r_mode && fall[c])))
            m[d][c] = bump(m[d][c], wid[d], sat[d]);
        end
      for (int s = 0; s < 4; s++) begin
        ui_in[7:6] = 2'(s);
        #1;
        for (int d = 0; d < 4; d++)
          check($sformatf("rnd%0d_d%0d_s%0d", it, d, s), outs[d],
                (s < nch[d]) ? 8'(m[d][s]) : 8'h00);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
